// File: rtl/measure_multi_ch.sv
// Round-robin multi-channel ultrasonic ranger: triggers one sensor per slot and
// measures its echo directly in mm. Optional per-channel 4-sample averaging via MEASURE_MULTI_CH_AVG_EN.
module measure_multi_ch #(
   parameter int unsigned CLK_FREQ = 50_000_000,
   parameter int unsigned CH_NUM   = 4,
   parameter int unsigned DIST_W   = 16,
   parameter int unsigned TRIG_US  = 10,
   parameter int unsigned SLOT_MS  = 60,
   parameter int unsigned MAX_MM   = 4000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [CH_NUM-1:0] ch_mask,
   input  logic [CH_NUM-1:0] echo,
   output logic [CH_NUM-1:0] trig,
   output logic [DIST_W-1:0] distance_data,
   output logic [2:0]        distance_ch,
   output logic              distance_err,
   output logic              distance_valid
);

   localparam int unsigned TRIG_CNT = TRIG_US * (CLK_FREQ / 1_000_000);
   localparam int unsigned SLOT_CNT = SLOT_MS * (CLK_FREQ / 1000);
   localparam int unsigned MM_CNT   = CLK_FREQ / 170_000;
   localparam int unsigned TRIG_W   = $clog2(TRIG_CNT + 1);
   localparam int unsigned SLOT_W   = $clog2(SLOT_CNT + 1);
   localparam int unsigned PSC_W    = $clog2(MM_CNT + 1);
   localparam int unsigned MM_W     = $clog2(MAX_MM + 1);
   localparam int unsigned CH_IW    = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
   localparam int unsigned SUM_W    = DIST_W + 2;

   typedef enum logic [2:0] {
      S_IDLE, S_TRIG, S_WAIT_RISE, S_MEASURE, S_DONE, S_HOLD
   } state_e;

   state_e            state_q;
   logic [CH_IW-1:0]  ptr_q;
   logic [CH_IW-1:0]  ch_q;
   logic [TRIG_W-1:0] trig_cnt_q;
   logic [SLOT_W-1:0] slot_cnt_q;
   logic [PSC_W-1:0]  psc_q;
   logic [MM_W-1:0]   mm_q;
   logic [CH_NUM-1:0] sync1_q, sync2_q, dly_q;
   logic [CH_NUM-1:0] trig_q;
   logic [DIST_W-1:0] data_q;
   logic [2:0]        dist_ch_q;
   logic              err_q;
   logic              valid_q;

   logic              found_d;
   logic [CH_IW-1:0]  next_ch_d;
   logic [CH_IW-1:0]  next_ptr_d;
   logic              echo_c, rise_c, fall_c;
   logic              wrap_c, slot_last_c, slot_end_c;
   logic [MM_W-1:0]   mm_d;
   logic              done_c, res_err_c;
   logic [DIST_W-1:0] res_data_c;
   logic [DIST_W-1:0] out_data_c;

   assign trig           = trig_q;
   assign distance_data  = data_q;
   assign distance_ch    = dist_ch_q;
   assign distance_err   = err_q;
   assign distance_valid = valid_q;

   // Two-flop synchroniser plus one delay flop for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         dly_q   <= '0;
      end else begin
         sync1_q <= echo;
         sync2_q <= sync1_q;
         dly_q   <= sync2_q;
      end
   end

   assign echo_c = sync2_q[ch_q];
   assign rise_c = echo_c & ~dly_q[ch_q];
   assign fall_c = ~echo_c & dly_q[ch_q];

   // First enabled channel at or after the pointer, wrapping
   always_comb begin
      int unsigned idx;
      idx       = 0;
      found_d   = 1'b0;
      next_ch_d = '0;
      for (int unsigned i = 0; i < CH_NUM; i++) begin
         idx = 32'(ptr_q) + i;
         if (idx >= CH_NUM) idx = idx - CH_NUM;
         if (!found_d && ch_mask[CH_IW'(idx)]) begin
            found_d   = 1'b1;
            next_ch_d = CH_IW'(idx);
         end
      end
   end

   assign next_ptr_d  = (ch_q == CH_IW'(CH_NUM - 1)) ? '0 : ch_q + CH_IW'(1);
   assign wrap_c      = (psc_q == PSC_W'(MM_CNT - 1));
   assign mm_d        = (wrap_c && mm_q != MM_W'(MAX_MM)) ? mm_q + MM_W'(1) : mm_q;
   // Results land on the final slot count at the latest, so every slot is SLOT_CNT+1 cycles
   assign slot_last_c = (slot_cnt_q == SLOT_W'(SLOT_CNT - 2));
   assign slot_end_c  = (slot_cnt_q == SLOT_W'(SLOT_CNT - 1));

   always_comb begin
      done_c     = 1'b0;
      res_err_c  = 1'b0;
      res_data_c = '0;
      case (state_q)
         S_WAIT_RISE: begin
            if (slot_last_c) begin
               done_c    = 1'b1;
               res_err_c = 1'b1;
            end
         end
         S_MEASURE: begin
            if (mm_d == MM_W'(MAX_MM) || slot_last_c) begin
               done_c     = 1'b1;
               res_err_c  = 1'b1;
               res_data_c = DIST_W'(MAX_MM);
            end else if (fall_c) begin
               done_c     = 1'b1;
               res_data_c = DIST_W'(mm_d);
            end
         end
         default: ;
      endcase
   end

`ifdef MEASURE_MULTI_CH_AVG_EN
   // Three previous good samples per channel; the current one completes the window of four
   logic [DIST_W-1:0] hist_q [CH_NUM][3];
   logic [1:0]        hcnt_q [CH_NUM];
   logic [SUM_W-1:0]  sum_c;

   assign sum_c = SUM_W'(res_data_c) + SUM_W'(hist_q[ch_q][0])
                + SUM_W'(hist_q[ch_q][1]) + SUM_W'(hist_q[ch_q][2]);
   assign out_data_c = (!res_err_c && hcnt_q[ch_q] == 2'd3) ? DIST_W'(sum_c >> 2) : res_data_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < CH_NUM; i++) begin
            hcnt_q[i] <= '0;
            for (int unsigned j = 0; j < 3; j++) hist_q[i][j] <= '0;
         end
      end else if (done_c && !res_err_c) begin
         hist_q[ch_q][0] <= res_data_c;
         hist_q[ch_q][1] <= hist_q[ch_q][0];
         hist_q[ch_q][2] <= hist_q[ch_q][1];
         if (hcnt_q[ch_q] != 2'd3) hcnt_q[ch_q] <= hcnt_q[ch_q] + 2'd1;
      end
   end
`else
   assign out_data_c = res_data_c;
`endif

   // Slot FSM with registered trigger and result outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         ptr_q      <= '0;
         ch_q       <= '0;
         trig_cnt_q <= '0;
         slot_cnt_q <= '0;
         psc_q      <= '0;
         mm_q       <= '0;
         trig_q     <= '0;
         data_q     <= '0;
         dist_ch_q  <= '0;
         err_q      <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         if (state_q != S_IDLE)
            slot_cnt_q <= slot_end_c ? '0 : slot_cnt_q + SLOT_W'(1);
         if (done_c) begin
            valid_q   <= 1'b1;
            data_q    <= out_data_c;
            err_q     <= res_err_c;
            dist_ch_q <= 3'(ch_q);
         end
         case (state_q)
            S_IDLE: begin
               if (found_d) begin
                  ch_q       <= next_ch_d;
                  trig_q     <= CH_NUM'(1) << next_ch_d;
                  slot_cnt_q <= '0;
                  trig_cnt_q <= '0;
                  psc_q      <= '0;
                  mm_q       <= '0;
                  state_q    <= S_TRIG;
               end
            end
            S_TRIG: begin
               if (trig_cnt_q == TRIG_W'(TRIG_CNT - 1)) begin
                  trig_q  <= '0;
                  state_q <= S_WAIT_RISE;
               end else begin
                  trig_cnt_q <= trig_cnt_q + TRIG_W'(1);
               end
            end
            S_WAIT_RISE: begin
               if (done_c) begin
                  state_q <= S_DONE;
               end else if (rise_c) begin
                  psc_q   <= '0;
                  mm_q    <= '0;
                  state_q <= S_MEASURE;
               end
            end
            S_MEASURE: begin
               psc_q <= wrap_c ? '0 : psc_q + PSC_W'(1);
               mm_q  <= mm_d;
               if (done_c) state_q <= S_DONE;
            end
            S_DONE, S_HOLD: begin
               if (slot_end_c) begin
                  ptr_q   <= next_ptr_d;
                  state_q <= S_IDLE;
               end else begin
                  state_q <= S_HOLD;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_measure_multi_ch.sv
// Directed bench for measure_multi_ch with a scaled clock (MM_CNT=10, TRIG_CNT=10, SLOT_CNT=1700).
module tb_measure_multi_ch;

   localparam int unsigned CLK_FREQ = 1_700_000;
   localparam int unsigned CH_NUM   = 4;
   localparam int unsigned DIST_W   = 16;
   localparam int unsigned TRIG_US  = 10;
   localparam int unsigned SLOT_MS  = 1;
   localparam int unsigned MAX_MM   = 100;
   localparam int          TRIG_CNT = 10;
   localparam int          SLOT_CNT = 1700;
   localparam int          MM_CNT   = 10;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [CH_NUM-1:0] ch_mask = '0;
   logic [CH_NUM-1:0] echo = '0;
   logic [CH_NUM-1:0] trig;
   logic [DIST_W-1:0] distance_data;
   logic [2:0]        distance_ch;
   logic              distance_err;
   logic              distance_valid;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int n_valid = 0;
   int n_bad_trig = 0;
   logic [CH_NUM-1:0] forbid = '0;

   measure_multi_ch #(
      .CLK_FREQ(CLK_FREQ), .CH_NUM(CH_NUM), .DIST_W(DIST_W),
      .TRIG_US(TRIG_US), .SLOT_MS(SLOT_MS), .MAX_MM(MAX_MM)
   ) dut (
      .clk(clk), .rst_n(rst_n), .ch_mask(ch_mask), .echo(echo), .trig(trig),
      .distance_data(distance_data), .distance_ch(distance_ch),
      .distance_err(distance_err), .distance_valid(distance_valid)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (distance_valid) n_valid++;
      if ((trig & forbid) != '0 || !$onehot0(trig)) n_bad_trig++;
   end

   task automatic do_reset();
      rst_n   = 1'b0;
      echo    = '0;
      ch_mask = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_trig(input int limit, output bit ok, output int at, output logic [CH_NUM-1:0] seen);
      int n;
      n = 0; ok = 1'b0; at = 0; seen = '0;
      while (!ok && n < limit) begin
         @(negedge clk);
         n++;
         if (trig != '0) begin
            ok = 1'b1; at = cyc; seen = trig;
         end
      end
   endtask

   task automatic wait_trig_low(output int w);
      w = 0;
      while (trig != '0 && w < 1000) begin
         w++;
         @(negedge clk);
      end
   endtask

   task automatic wait_valid(input int limit, output bit ok, output int at);
      int n;
      n = 0; ok = 1'b0; at = 0;
      while (!ok && n < limit) begin
         @(negedge clk);
         n++;
         if (distance_valid) begin
            ok = 1'b1; at = cyc;
         end
      end
   endtask

   task automatic pulse_echo(input int ch, input int n);
      echo[ch] = 1'b1;
      repeat (n) @(negedge clk);
      echo[ch] = 1'b0;
   endtask

   task automatic test_reset();
      logic [CH_NUM+DIST_W+4:0] got;
      int tcount;
      rst_n = 1'b0;
      ch_mask = 4'b1111;
      echo = 4'b1111;
      repeat (3) @(negedge clk);
      got = {trig, distance_data, distance_ch, distance_err, distance_valid};
      checks++;
      if (got !== '0) begin
         errors++; $display("FAIL reset_outputs: got %h expected 0", got);
      end
      do_reset();
      tcount = 0;
      repeat (20) begin
         @(negedge clk);
         if (trig != '0) tcount++;
      end
      checks++;
      if (tcount !== 0) begin
         errors++; $display("FAIL reset_idle_trig: got %0d trig cycles expected 0", tcount);
      end
   endtask

   task automatic test_single();
      bit ok; int at; int w; logic [CH_NUM-1:0] seen; logic [19:0] got;
      do_reset();
      ch_mask = 4'b0001;
      wait_trig(20, ok, at, seen);
      checks++;
      if (!ok || seen !== 4'b0001) begin
         errors++; $display("FAIL single_trig_ch: got ok=%0d trig=%b expected trig=0001", ok, seen);
      end
      wait_trig_low(w);
      checks++;
      if (w !== TRIG_CNT) begin
         errors++; $display("FAIL single_trig_width: got %0d expected %0d", w, TRIG_CNT);
      end
      repeat (3) @(negedge clk);
      pulse_echo(0, 50 * MM_CNT);
      wait_valid(50, ok, at);
      got = {distance_ch, distance_err, distance_data};
      checks++;
      if (!ok || got !== {3'd0, 1'b0, 16'd50}) begin
         errors++; $display("FAIL single_result: got ok=%0d ch/err/data=%h expected 0/0/50 (%h)", ok, got, {3'd0, 1'b0, 16'd50});
      end
      repeat (5) @(negedge clk);
      checks++;
      if (distance_valid !== 1'b0 || distance_data !== 16'd50) begin
         errors++; $display("FAIL single_hold: got valid=%0d data=%0d expected valid=0 data=50", distance_valid, distance_data);
      end
   endtask

   task automatic test_alternate();
      bit ok; int at; int prev_at; int w; int expch; int d; int bad_base;
      logic [CH_NUM-1:0] seen; logic [CH_NUM-1:0] exp_trig; logic [19:0] got; logic [19:0] exp;
      do_reset();
      bad_base = n_bad_trig;
      forbid = 4'b0101;
      ch_mask = 4'b1010;
      prev_at = 0;
      for (int s = 0; s < 4; s++) begin
         expch = (s % 2 == 0) ? 1 : 3;
         d = (expch == 1) ? 25 : 75;
         exp_trig = 4'b0001 << expch;
         wait_trig(SLOT_CNT + 20, ok, at, seen);
         checks++;
         if (!ok || seen !== exp_trig) begin
            errors++; $display("FAIL alt_trig_ch slot %0d: got ok=%0d trig=%b expected %b", s, ok, seen, exp_trig);
         end
         if (s > 0) begin
            checks++;
            if (at - prev_at !== SLOT_CNT + 1) begin
               errors++; $display("FAIL alt_slot_period slot %0d: got %0d expected %0d", s, at - prev_at, SLOT_CNT + 1);
            end
         end
         prev_at = at;
         wait_trig_low(w);
         repeat (3) @(negedge clk);
         pulse_echo(expch, d * MM_CNT);
         wait_valid(50, ok, at);
         got = {distance_ch, distance_err, distance_data};
         exp = {3'(expch), 1'b0, 16'(d)};
         checks++;
         if (!ok || got !== exp) begin
            errors++; $display("FAIL alt_result slot %0d: got ok=%0d ch/err/data=%h expected %h", s, ok, got, exp);
         end
      end
      checks++;
      if (n_bad_trig !== bad_base) begin
         errors++; $display("FAIL alt_disabled_trig: got %0d bad trig cycles expected 0", n_bad_trig - bad_base);
      end
      forbid = '0;
   endtask

   task automatic test_no_echo();
      bit ok; int at; int vat; logic [CH_NUM-1:0] seen; logic [19:0] got;
      do_reset();
      ch_mask = 4'b0001;
      wait_trig(20, ok, at, seen);
      wait_valid(SLOT_CNT + 20, ok, vat);
      got = {distance_ch, distance_err, distance_data};
      checks++;
      if (!ok || got !== {3'd0, 1'b1, 16'd0}) begin
         errors++; $display("FAIL noecho_result: got ok=%0d ch/err/data=%h expected %h", ok, got, {3'd0, 1'b1, 16'd0});
      end
      checks++;
      if (vat - at !== SLOT_CNT - 1) begin
         errors++; $display("FAIL noecho_timing: got %0d expected %0d", vat - at, SLOT_CNT - 1);
      end
   endtask

   task automatic test_echo_early();
      bit ok; int at; int w; logic [CH_NUM-1:0] seen; logic [19:0] got;
      do_reset();
      ch_mask = 4'b0001;
      wait_trig(20, ok, at, seen);
      echo[0] = 1'b1;
      wait_valid(SLOT_CNT + 20, ok, at);
      got = {distance_ch, distance_err, distance_data};
      checks++;
      if (!ok || got !== {3'd0, 1'b1, 16'd0}) begin
         errors++; $display("FAIL early_echo_result: got ok=%0d ch/err/data=%h expected %h", ok, got, {3'd0, 1'b1, 16'd0});
      end
      echo[0] = 1'b0;
      wait_trig(SLOT_CNT + 20, ok, at, seen);
      wait_trig_low(w);
      repeat (3) @(negedge clk);
      pulse_echo(0, 20 * MM_CNT);
      wait_valid(50, ok, at);
      got = {distance_ch, distance_err, distance_data};
      checks++;
      if (!ok || got !== {3'd0, 1'b0, 16'd20}) begin
         errors++; $display("FAIL early_echo_recover: got ok=%0d ch/err/data=%h expected %h", ok, got, {3'd0, 1'b0, 16'd20});
      end
   endtask

   task automatic test_stuck();
      bit ok; int at; int w; logic [CH_NUM-1:0] seen; logic [19:0] got;
      do_reset();
      ch_mask = 4'b0001;
      wait_trig(20, ok, at, seen);
      wait_trig_low(w);
      repeat (3) @(negedge clk);
      echo[0] = 1'b1;
      wait_valid(1500, ok, at);
      got = {distance_ch, distance_err, distance_data};
      checks++;
      if (!ok || got !== {3'd0, 1'b1, 16'd100}) begin
         errors++; $display("FAIL stuck_result: got ok=%0d ch/err/data=%h expected %h", ok, got, {3'd0, 1'b1, 16'd100});
      end
      echo[0] = 1'b0;
   endtask

   task automatic test_mask_and_reset();
      bit ok; int at; int w; int tcount; int vbase; logic [CH_NUM-1:0] seen;
      logic [19:0] got; logic [CH_NUM+DIST_W+4:0] all_out;
      do_reset();
      vbase = n_valid;
      tcount = 0;
      repeat (3 * (SLOT_CNT + 1)) begin
         @(negedge clk);
         if (trig != '0) tcount++;
      end
      checks++;
      if (tcount !== 0 || n_valid !== vbase) begin
         errors++; $display("FAIL mask0_idle: got trig=%0d strobes=%0d expected 0 and 0", tcount, n_valid - vbase);
      end
      ch_mask = 4'b0100;
      wait_trig(5, ok, at, seen);
      checks++;
      if (!ok || seen !== 4'b0100) begin
         errors++; $display("FAIL mask_set_trig: got ok=%0d trig=%b expected 0100", ok, seen);
      end
      wait_trig_low(w);
      repeat (3) @(negedge clk);
      pulse_echo(2, 30 * MM_CNT);
      wait_valid(50, ok, at);
      got = {distance_ch, distance_err, distance_data};
      checks++;
      if (!ok || got !== {3'd2, 1'b0, 16'd30}) begin
         errors++; $display("FAIL mask_set_result: got ok=%0d ch/err/data=%h expected %h", ok, got, {3'd2, 1'b0, 16'd30});
      end
      wait_trig(SLOT_CNT + 20, ok, at, seen);
      checks++;
      if (!ok || seen !== 4'b0100) begin
         errors++; $display("FAIL mask_wrap_trig: got ok=%0d trig=%b expected 0100", ok, seen);
      end
      wait_trig_low(w);
      repeat (3) @(negedge clk);
      echo[2] = 1'b1;
      repeat (100) @(negedge clk);
      rst_n = 1'b0;
      #1;
      all_out = {trig, distance_data, distance_ch, distance_err, distance_valid};
      checks++;
      if (all_out !== '0) begin
         errors++; $display("FAIL midreset_outputs: got %h expected 0", all_out);
      end
      echo = '0;
      ch_mask = '0;
      @(negedge clk);
      rst_n = 1'b1;
      vbase = n_valid;
      repeat (50) @(negedge clk);
      checks++;
      if (n_valid !== vbase) begin
         errors++; $display("FAIL midreset_no_strobe: got %0d strobes expected 0", n_valid - vbase);
      end
   endtask

`ifdef MEASURE_MULTI_CH_AVG_EN
   task automatic test_avg();
      bit ok; int at; int w; logic [CH_NUM-1:0] seen; logic [19:0] got; logic [19:0] exp;
      int exp_avg [5];
      exp_avg = '{10, 20, 30, 25, 35};
      do_reset();
      ch_mask = 4'b0001;
      for (int s = 0; s < 5; s++) begin
         wait_trig(SLOT_CNT + 20, ok, at, seen);
         wait_trig_low(w);
         repeat (3) @(negedge clk);
         pulse_echo(0, (s + 1) * 10 * MM_CNT);
         wait_valid(50, ok, at);
         got = {distance_ch, distance_err, distance_data};
         exp = {3'd0, 1'b0, 16'(exp_avg[s])};
         checks++;
         if (!ok || got !== exp) begin
            errors++; $display("FAIL avg_sample %0d: got ok=%0d ch/err/data=%h expected %h", s, ok, got, exp);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_alternate();
      test_no_echo();
      test_echo_early();
      test_stuck();
      test_mask_and_reset();
`ifdef MEASURE_MULTI_CH_AVG_EN
      test_avg();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
